imm_ext_pipe: RTL
=================

Name: imm_ext_pipe

Overview:
- Parametrised, registered immediate/shift-amount extender for the decode-to-execute boundary of the MIPS pipeline.
- Decodes op/funct from the full instruction word and selects one of sign-extend, zero-extend, shamt-extend, LUI-shift or zero.
- Output is registered behind a valid/ready handshake with a 2-entry skid buffer, so the block absorbs execute-stage stalls without combinational ready paths.
- Also supports flush on branch redirect and keeps a saturating count of accepted instructions.

Parameters:
- XLEN, 32, width of the extended output.
- IMM_W, 16, immediate field width, taken from instr[IMM_W-1:0].
- SHAMT_W, 5, shift-amount field width, taken from instr[6+SHAMT_W-1:6].
- CNT_W, 16, width of the accepted-instruction counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  block can accept; equals NOT skid_valid (combinational from state only).
- in_instr  in  32  instruction word; op=[31:26], funct=[5:0].
- flush  in  1  redirect: discard all held entries and the current input.
- out_valid  out  1  out_ext/out_mode hold a valid result.
- out_ready  in  1  downstream accepts this cycle.
- out_ext  out  XLEN  extended value.
- out_mode  out  3  0=NONE, 1=SIGN, 2=ZERO, 3=SHAMT, 4=LUI.
- out_unk  out  1  op not recognised (mode NONE, out_ext=0).
- acc_cnt  out  CNT_W  saturating count of accepted inputs.

Behaviour:
- Decode priority, evaluated top to bottom:
  - op==6'h01 (REGIMM) -> NONE, 0, unk=0.
  - op in {08,09,23,2b,0a,24} -> SIGN, {{XLEN-IMM_W{imm[IMM_W-1]}},imm}.
  - op in {0c,0d,0e} -> ZERO, {0,imm}.
  - op==6'h0f -> LUI, imm<<16, zero-filled to XLEN.
  - op==0 and funct in {00,02,03} -> SHAMT, {0,shamt}.
  - op==0, other funct -> NONE, 0, unk=0.
  - any other op -> NONE, 0, unk=1.
- Accept: in_valid & in_ready & ~flush & ~rst.
- Latency: 1 cycle. A result accepted at edge N is visible at edge N+1 when the output register is empty or draining.
- Output register (out_*) plus one skid entry; both reset to empty/zero. While rst is high, in_ready=1 but nothing is accepted.
- Per edge, with out_fire = out_valid & out_ready:
  - Output empty or out_fire: load the output from skid if skid_valid, else from the accepted input, else out_valid<=0. If skid was used and an input is also accepted, the input goes to skid.
  - Output full and not out_fire: an accepted input goes to skid. It cannot be accepted if skid is full, because in_ready=0.
- Order is strictly preserved. No loss and no duplication.
- out_* are stable while out_valid & ~out_ready.
- flush, which has priority over everything except rst: next cycle out_valid=0, skid_valid=0, in_ready=1. The same-cycle input is dropped and not counted. A same-cycle out_fire still completes from the downstream view.
- acc_cnt increments by 1 per accept and saturates at 2^CNT_W-1. It is not affected by flush; it is cleared only by rst.
- Reset values: out_valid=0, out_ext=0, out_mode=0, out_unk=0, acc_cnt=0, skid empty.
- Reset mid-operation discards all entries; the first accept is possible on the first edge after rst deasserts.
- Width rules:
  - XLEN < IMM_W+16 is illegal and must be caught by an elaboration-time check.
  - SHAMT field bits above SHAMT_W are ignored.

Decomposition:
- Package imm_ext_pkg holds:
  - the mode encodings (EXT_NONE..EXT_LUI);
  - opcode constants (OP_REGIMM, OP_ADDI, OP_ADDIU, OP_LW, OP_SW, OP_SLTI, OP_LBU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_RTYPE);
  - funct constants (FN_SLL, FN_SRL, FN_SRA).
- One sub-module, imm_ext_dec: purely combinational, instr -> {ext, mode, unk}.
- The top level holds the skid/handshake logic and the counter.

Test Plan:
1. addi instr 0x2008FFF0, out_ready=1 -> next cycle out_valid=1, out_ext=0xFFFFFFF0, mode=1; acc_cnt=1.
2. ori 0x34088000 -> 0x00008000 mode=2. lui 0x3C011234 -> 0x12340000 mode=4. bgez (op 01) -> 0x0, mode=0, unk=0. op 0x3F -> 0, unk=1.
3. sll instr 0x000941C0 -> 0x00000007 mode=3. R-type add (funct 0x20) -> 0, mode=0, unk=0.
4. out_ready=0, stream addi imm 1,2,3 back-to-back:
   - in_ready drops after the 2nd accept; the 3rd is held upstream.
   - Raise out_ready: outputs 1, 2, 3 in order on consecutive cycles.
   - acc_cnt=3.
5. Both entries full, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1; acc_cnt unchanged; the following input emerges alone.
6. rst high for 1 cycle mid-stream -> all outputs zero, acc_cnt=0. With CNT_W=2, 5 accepts -> acc_cnt=3 (saturated).

Source files
------------

// File: rtl/imm_ext_pkg.sv
// Shared encodings for the immediate/shift-amount extender: extension modes,
// MIPS opcode and funct constants, and a small decode helper.
package imm_ext_pkg;

  typedef enum logic [2:0] {
    EXT_NONE  = 3'd0,
    EXT_SIGN  = 3'd1,
    EXT_ZERO  = 3'd2,
    EXT_SHAMT = 3'd3,
    EXT_LUI   = 3'd4
  } ext_mode_e;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0a;
  localparam logic [5:0] OP_ANDI   = 6'h0c;
  localparam logic [5:0] OP_ORI    = 6'h0d;
  localparam logic [5:0] OP_XORI   = 6'h0e;
  localparam logic [5:0] OP_LUI    = 6'h0f;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_LBU    = 6'h24;
  localparam logic [5:0] OP_SW     = 6'h2b;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_SRA = 6'h03;

  localparam int unsigned LUI_SHIFT = 16;

  // Only the immediate-shift R-type functs carry a shamt field.
  function automatic logic is_shamt_funct(input logic [5:0] funct);
    return (funct == FN_SLL) || (funct == FN_SRL) || (funct == FN_SRA);
  endfunction

endpackage

// File: rtl/imm_ext_dec.sv
// Combinational decode of an instruction word into its extended immediate,
// the extension mode used and an unknown-opcode flag.
module imm_ext_dec
  import imm_ext_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned IMM_W   = 16,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic [31:0]     i_instr,
  output logic [XLEN-1:0] o_ext,
  output ext_mode_e       o_mode,
  output logic            o_unk
);

  logic [5:0]         w_op;
  logic [5:0]         w_funct;
  logic [IMM_W-1:0]   w_imm;
  logic [SHAMT_W-1:0] w_shamt;
  logic [XLEN-1:0]    w_imm_sext;
  logic [XLEN-1:0]    w_imm_zext;
  logic [XLEN-1:0]    w_shamt_zext;
  logic               w_unused_instr;

  assign w_op           = i_instr[31:26];
  assign w_funct        = i_instr[5:0];
  assign w_imm          = i_instr[IMM_W-1:0];
  assign w_shamt        = i_instr[6 +: SHAMT_W];
  assign w_unused_instr = ^i_instr;

  assign w_imm_sext   = XLEN'($signed(w_imm));
  assign w_imm_zext   = XLEN'(w_imm);
  assign w_shamt_zext = XLEN'(w_shamt);

  always_comb begin
    o_ext  = '0;
    o_mode = EXT_NONE;
    o_unk  = 1'b0;
    case (w_op)
      OP_REGIMM: ;
      OP_ADDI, OP_ADDIU, OP_LW, OP_SW, OP_SLTI, OP_LBU: begin
        o_ext  = w_imm_sext;
        o_mode = EXT_SIGN;
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        o_ext  = w_imm_zext;
        o_mode = EXT_ZERO;
      end
      OP_LUI: begin
        o_ext  = w_imm_zext << LUI_SHIFT;
        o_mode = EXT_LUI;
      end
      OP_RTYPE: begin
        // Non-shift R-types are known but carry no immediate.
        if (is_shamt_funct(w_funct)) begin
          o_ext  = w_shamt_zext;
          o_mode = EXT_SHAMT;
        end
      end
      default: o_unk = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_ext_pipe.sv
// Registered immediate extender with a 2-entry (output + skid) valid/ready
// stage, redirect flush and a saturating accepted-instruction counter.
module imm_ext_pipe
  import imm_ext_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned IMM_W   = 16,
  parameter int unsigned SHAMT_W = 5,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_ext,
  output logic [2:0]       out_mode,
  output logic             out_unk,
  output logic [CNT_W-1:0] acc_cnt
);

  if (XLEN < IMM_W + 16) begin : g_bad_xlen
    $error("imm_ext_pipe: XLEN must be at least IMM_W+16 to hold a LUI result");
  end

  logic [XLEN-1:0]  w_dec_ext;
  ext_mode_e        w_dec_mode;
  logic             w_dec_unk;
  logic             w_accept;
  logic             w_out_fire;
  logic             w_out_free;

  logic             r_out_valid;
  logic [XLEN-1:0]  r_out_ext;
  ext_mode_e        r_out_mode;
  logic             r_out_unk;
  logic             r_skid_valid;
  logic [XLEN-1:0]  r_skid_ext;
  ext_mode_e        r_skid_mode;
  logic             r_skid_unk;
  logic [CNT_W-1:0] r_acc_cnt;

  imm_ext_dec #(
    .XLEN    (XLEN),
    .IMM_W   (IMM_W),
    .SHAMT_W (SHAMT_W)
  ) u_dec (
    .i_instr (in_instr),
    .o_ext   (w_dec_ext),
    .o_mode  (w_dec_mode),
    .o_unk   (w_dec_unk)
  );

  assign in_ready   = ~r_skid_valid;
  assign w_accept   = in_valid & in_ready & ~flush & ~rst;
  assign w_out_fire = r_out_valid & out_ready;
  assign w_out_free = ~r_out_valid | w_out_fire;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_out_ext    <= '0;
      r_out_mode   <= EXT_NONE;
      r_out_unk    <= 1'b0;
      r_skid_valid <= 1'b0;
      r_skid_ext   <= '0;
      r_skid_mode  <= EXT_NONE;
      r_skid_unk   <= 1'b0;
    end else if (flush) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (w_out_free) begin
      if (r_skid_valid) begin
        // Skid is older than anything arriving now, so it drains first.
        r_out_valid  <= 1'b1;
        r_out_ext    <= r_skid_ext;
        r_out_mode   <= r_skid_mode;
        r_out_unk    <= r_skid_unk;
        r_skid_valid <= w_accept;
        if (w_accept) begin
          r_skid_ext  <= w_dec_ext;
          r_skid_mode <= w_dec_mode;
          r_skid_unk  <= w_dec_unk;
        end
      end else if (w_accept) begin
        r_out_valid <= 1'b1;
        r_out_ext   <= w_dec_ext;
        r_out_mode  <= w_dec_mode;
        r_out_unk   <= w_dec_unk;
      end else begin
        r_out_valid <= 1'b0;
      end
    end else if (w_accept) begin
      r_skid_valid <= 1'b1;
      r_skid_ext   <= w_dec_ext;
      r_skid_mode  <= w_dec_mode;
      r_skid_unk   <= w_dec_unk;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc_cnt <= '0;
    end else if (w_accept && (r_acc_cnt != {CNT_W{1'b1}})) begin
      r_acc_cnt <= r_acc_cnt + CNT_W'(1);
    end
  end

  assign out_valid = r_out_valid;
  assign out_ext   = r_out_ext;
  assign out_mode  = r_out_mode;
  assign out_unk   = r_out_unk;
  assign acc_cnt   = r_acc_cnt;

endmodule
